// File: rtl/ysyx_22041207_trap_ctrl.sv
// Trap sequencer: takes exceptions, the machine timer interrupt and mret, drives the CSR side-band writes and one IFU redirect.
// Optional feature macro TRAP_VECTORED_EN enables vectored mtvec mode for interrupts; without it every trap uses the mtvec base.
module ysyx_22041207_trap_ctrl #(
  parameter int XLEN     = 64,
  parameter int CNT_W    = 32,
  parameter int IRQ_CODE = 7
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             exc_valid,
  output logic             exc_ready,
  input  logic [XLEN-1:0]  exc_cause,
  input  logic [XLEN-1:0]  exc_pc,
  input  logic             mret_valid,
  input  logic             irq_mtip,
  input  logic [XLEN-1:0]  mstatus_i,
  input  logic [XLEN-1:0]  mtvec_i,
  input  logic [XLEN-1:0]  mepc_i,
  output logic             wMepc,
  output logic [XLEN-1:0]  mepc_v,
  output logic             wMcause,
  output logic [XLEN-1:0]  mcause_v,
  output logic             panic,
  output logic             pc_mret,
  output logic             redirect_valid,
  output logic [XLEN-1:0]  redirect_pc,
  input  logic             redirect_ready,
  output logic             busy,
  output logic [CNT_W-1:0] trap_cnt
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SAVE  = 2'd1,
    RET   = 2'd2,
    REDIR = 2'd3
  } state_t;

  state_t           state_r;
  state_t           state_s;
  logic [XLEN-1:0]  cause_r;
  logic [XLEN-1:0]  epc_r;
  logic [XLEN-1:0]  target_r;
  logic [XLEN-1:0]  vec_target_s;
  logic [CNT_W-1:0] trap_cnt_r;
  logic             irq_take_s;
  logic             unused_s;

  assign irq_take_s = irq_mtip & mstatus_i[3];
  assign unused_s   = ^{mstatus_i[XLEN-1:4], mstatus_i[2:0], mtvec_i[1:0]};

  // Trap vector for the captured cause, evaluated against mtvec as seen in SAVE.
  always_comb begin
    vec_target_s = {mtvec_i[XLEN-1:2], 2'b00};
`ifdef TRAP_VECTORED_EN
    if ((mtvec_i[1:0] == 2'b01) && cause_r[XLEN-1]) begin
      vec_target_s = {mtvec_i[XLEN-1:2], 2'b00} + {cause_r[XLEN-3:0], 2'b00};
    end else begin
      vec_target_s = {mtvec_i[XLEN-1:2], 2'b00};
    end
`endif
  end

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_s;
    end
  end

  // Next-state logic; exception beats interrupt beats mret in IDLE.
  always_comb begin
    state_s = state_r;
    case (state_r)
      IDLE: begin
        if (exc_valid || irq_take_s) begin
          state_s = SAVE;
        end else if (mret_valid) begin
          state_s = RET;
        end else begin
          state_s = IDLE;
        end
      end
      SAVE:    state_s = REDIR;
      RET:     state_s = REDIR;
      REDIR: begin
        if (redirect_ready) begin
          state_s = IDLE;
        end else begin
          state_s = REDIR;
        end
      end
      default: state_s = IDLE;
    endcase
  end

  // Capture registers for cause/epc/redirect target and the trap-entry counter.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cause_r    <= {XLEN{1'b0}};
      epc_r      <= {XLEN{1'b0}};
      target_r   <= {XLEN{1'b0}};
      trap_cnt_r <= {CNT_W{1'b0}};
    end else begin
      case (state_r)
        IDLE: begin
          if (exc_valid) begin
            cause_r <= exc_cause;
            epc_r   <= exc_pc;
          end else if (irq_take_s) begin
            cause_r <= {1'b1, (XLEN-1)'(IRQ_CODE)};
            epc_r   <= exc_pc;
          end
        end
        SAVE: begin
          target_r   <= vec_target_s;
          trap_cnt_r <= trap_cnt_r + {{(CNT_W-1){1'b0}}, 1'b1};
        end
        RET:     target_r <= mepc_i;
        default: ;
      endcase
    end
  end

  // Output decode from the state register; strobes exist only in SAVE/RET.
  always_comb begin
    exc_ready      = (state_r == IDLE);
    busy           = (state_r != IDLE);
    wMepc          = (state_r == SAVE);
    wMcause        = (state_r == SAVE);
    panic          = (state_r == SAVE);
    pc_mret        = (state_r == RET);
    redirect_valid = (state_r == REDIR);
    mepc_v         = (state_r == SAVE)  ? epc_r    : {XLEN{1'b0}};
    mcause_v       = (state_r == SAVE)  ? cause_r  : {XLEN{1'b0}};
    redirect_pc    = (state_r == REDIR) ? target_r : {XLEN{1'b0}};
    trap_cnt       = trap_cnt_r;
  end

endmodule
